tx_hs_burst_ctrl: RTL and testbench



---
 rtl/tx_hs_burst_ctrl.sv | 114 +++++++++++
 tb/tb_tx_hs_burst_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_hs_burst_ctrl.sv
// Burst feeder for the DPHY TX high-speed FSM: a show-ahead byte FIFO whose pops
// are paced by DphyTxState so every byte lands on a DATA cycle.
module tx_hs_burst_ctrl #(
   parameter int          DEPTH    = 16,
   parameter int          IDLE_GAP = 4,
   parameter logic [2:0]  ST_STOP  = 3'b000,
   parameter logic [2:0]  ST_DATA  = 3'b010
) (
   input  logic       TxDDRClk,
   input  logic       TxRst,
   input  logic       PktValid,
   input  logic [7:0] PktData,
   input  logic       PktLast,
   output logic       PktReady,
   input  logic [2:0] DphyTxState,
   output logic       HSTX_EN,
   output logic [7:0] TxData,
   output logic       BurstActive,
   output logic       UnderrunErr
);

   // state  | meaning
   // S_IDLE | waiting for a complete packet (or full FIFO) and the STOP gap
   // S_REQ  | HSTX_EN raised, waiting for the HS FSM to reach DATA
   // S_SEND | popping one byte per DATA cycle until last byte or underrun
   // S_END  | HSTX_EN dropped, waiting for the HS FSM to return to STOP
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND, S_END} state_t;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(IDLE_GAP + 1);

   logic [8:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   state_t        state_q, state_d;
   logic          hstx_en_q, hstx_en_d;

   logic full, empty, push, pop, pop_en, head_last, underrun;

   assign full      = (fifo_cnt_q == CW'(DEPTH));
   assign empty     = (fifo_cnt_q == '0);
   assign push      = PktValid && !full;
   assign pop_en    = ((state_q == S_REQ) || (state_q == S_SEND)) && (DphyTxState == ST_DATA);
   assign pop       = pop_en && !empty;
   assign underrun  = pop_en && empty;
   assign head_last = mem_q[rd_ptr_q][8];

   assign PktReady    = !full;
   assign TxData      = empty ? 8'h00 : mem_q[rd_ptr_q][7:0];
   assign HSTX_EN     = hstx_en_q;
   assign BurstActive = (state_q != S_IDLE);
   assign UnderrunErr = underrun;

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
      pkt_cnt_d  = pkt_cnt_q + CW'(push && PktLast) - CW'(pop && head_last);

      gap_d = gap_q;
      if (DphyTxState != ST_STOP)
         gap_d = '0;
      else if (gap_q != GW'(IDLE_GAP))
         gap_d = gap_q + GW'(1);

      state_d = state_q;
      case (state_q)
         S_IDLE:
            if (((pkt_cnt_q != '0) || full) && (gap_q == GW'(IDLE_GAP)))
               state_d = S_REQ;
         S_REQ, S_SEND:
            // the burst closes on the cycle the last byte (or nothing) is presented
            if (pop_en)
               state_d = (empty || head_last) ? S_END : S_SEND;
         S_END:
            if (DphyTxState == ST_STOP)
               state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase

      hstx_en_d = (state_d == S_REQ) || (state_d == S_SEND);
   end

   always_ff @(posedge TxDDRClk) begin
      if (push)
         mem_q[wr_ptr_q] <= {PktLast, PktData};
   end

   always_ff @(posedge TxDDRClk or posedge TxRst) begin
      if (TxRst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         gap_q      <= '0;
         state_q    <= S_IDLE;
         hstx_en_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         gap_q      <= gap_d;
         state_q    <= state_d;
         hstx_en_q  <= hstx_en_d;
      end
   end

endmodule

// File: tb/tb_tx_hs_burst_ctrl.sv
// Bench for tx_hs_burst_ctrl: behavioural HS FSM (STOP->GO x11->SYNC->DATA->TRAIL)
// plus a byte scoreboard filled on accepted pushes and drained on DATA cycles.
module tb_tx_hs_burst_ctrl;

   localparam int         DEPTH    = 16;
   localparam int         IDLE_GAP = 4;
   localparam logic [2:0] ST_STOP  = 3'b000;
   localparam logic [2:0] ST_GO    = 3'b001;
   localparam logic [2:0] ST_SYNC  = 3'b011;
   localparam logic [2:0] ST_DATA  = 3'b010;
   localparam logic [2:0] ST_TRAIL = 3'b100;

   logic       TxDDRClk = 1'b0;
   logic       TxRst;
   logic       PktValid;
   logic [7:0] PktData;
   logic       PktLast;
   logic       PktReady;
   logic [2:0] DphyTxState = ST_STOP;
   logic       HSTX_EN;
   logic [7:0] TxData;
   logic       BurstActive;
   logic       UnderrunErr;

   int         errors = 0;
   int         checks = 0;
   logic [8:0] exp_q [$];
   int         sent_cnt = 0;
   int         underrun_cnt = 0;
   int         rise_cnt = 0;
   int         stop_run = 0;
   bit         expect_fall = 1'b0;
   bit         prev_en = 1'b0;
   int         hs_cnt = 0;

   always #5 TxDDRClk = ~TxDDRClk;

   tx_hs_burst_ctrl #(
      .DEPTH(DEPTH), .IDLE_GAP(IDLE_GAP), .ST_STOP(ST_STOP), .ST_DATA(ST_DATA)
   ) dut (
      .TxDDRClk(TxDDRClk), .TxRst(TxRst),
      .PktValid(PktValid), .PktData(PktData), .PktLast(PktLast), .PktReady(PktReady),
      .DphyTxState(DphyTxState), .HSTX_EN(HSTX_EN), .TxData(TxData),
      .BurstActive(BurstActive), .UnderrunErr(UnderrunErr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // HS FSM model, updated just after each active edge
   always begin
      @(posedge TxDDRClk);
      #1;
      if (TxRst) begin
         DphyTxState = ST_STOP;
         hs_cnt = 0;
      end else begin
         case (DphyTxState)
            ST_STOP:  if (HSTX_EN) begin DphyTxState = ST_GO; hs_cnt = 1; end
            ST_GO:    if (hs_cnt == 11) DphyTxState = ST_SYNC; else hs_cnt++;
            ST_SYNC:  DphyTxState = ST_DATA;
            ST_DATA:  if (!HSTX_EN) begin DphyTxState = ST_TRAIL; hs_cnt = 1; end
            ST_TRAIL: if (hs_cnt == 3) DphyTxState = ST_STOP; else hs_cnt++;
            default:  DphyTxState = ST_STOP;
         endcase
      end
   end

   // Output monitor, sampled mid-cycle
   always @(negedge TxDDRClk) begin
      logic [8:0] e;
      if (HSTX_EN && !prev_en) begin
         rise_cnt++;
         chk("gap", 32'(stop_run >= IDLE_GAP), 32'd1);
      end
      if (DphyTxState == ST_STOP) stop_run++;
      else stop_run = 0;
      if (expect_fall) begin
         chk("sot_fall", 32'(HSTX_EN), 32'd0);
         expect_fall = 1'b0;
      end
      if (DphyTxState == ST_DATA && HSTX_EN) begin
         sent_cnt++;
         chk("busy", 32'(BurstActive), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("data", 32'(TxData), 32'(e[7:0]));
            chk("no_underrun", 32'(UnderrunErr), 32'd0);
            if (e[8]) expect_fall = 1'b1;
         end else begin
            chk("underrun_data", 32'(TxData), 32'd0);
            chk("underrun", 32'(UnderrunErr), 32'd1);
            expect_fall = 1'b1;
         end
      end
      if (UnderrunErr) underrun_cnt++;
      prev_en = HSTX_EN;
   end

   task automatic push_byte(input logic [7:0] d, input bit l);
      int t = 0;
      @(negedge TxDDRClk);
      PktValid = 1'b1;
      PktData  = d;
      PktLast  = l;
      while (!PktReady && t < 500) begin
         @(negedge TxDDRClk);
         t++;
      end
      if (!PktReady) begin
         chk("push_timeout", 32'(PktReady), 32'd1);
         PktValid = 1'b0;
      end else begin
         @(posedge TxDDRClk);
         exp_q.push_back({l, d});
         #1;
         PktValid = 1'b0;
         PktLast  = 1'b0;
      end
   endtask

   task automatic push_seq(input logic [7:0] base, input int n, input bit last_at_end);
      for (int i = 0; i < n; i++)
         push_byte(base + 8'(i), last_at_end && (i == n - 1));
   endtask

   task automatic wait_idle();
      int t = 0;
      @(negedge TxDDRClk);
      while ((exp_q.size() != 0 || BurstActive || HSTX_EN || DphyTxState != ST_STOP) && t < 1000) begin
         @(negedge TxDDRClk);
         t++;
      end
      chk("idle_timeout", 32'(t < 1000), 32'd1);
      repeat (2) @(negedge TxDDRClk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int base_sent, base_ur, base_rise, t;
      TxRst = 1'b1; PktValid = 1'b0; PktData = 8'h00; PktLast = 1'b0;
      repeat (3) @(posedge TxDDRClk);
      #1;
      chk("rst_hstx", 32'(HSTX_EN), 32'd0);
      chk("rst_busy", 32'(BurstActive), 32'd0);
      chk("rst_underrun", 32'(UnderrunErr), 32'd0);
      chk("rst_txdata", 32'(TxData), 32'd0);
      chk("rst_ready", 32'(PktReady), 32'd1);
      @(posedge TxDDRClk);
      #2 TxRst = 1'b0;
      repeat (8) @(negedge TxDDRClk);

      // 4-byte packet, SOT one cycle after last push
      base_sent = sent_cnt; base_ur = underrun_cnt;
      push_seq(8'hA1, 4, 1'b1);
      @(negedge TxDDRClk);
      chk("t1_sot_wait", 32'(HSTX_EN), 32'd0);
      chk("t1_busy_wait", 32'(BurstActive), 32'd0);
      @(negedge TxDDRClk);
      chk("t1_sot_rise", 32'(HSTX_EN), 32'd1);
      chk("t1_busy", 32'(BurstActive), 32'd1);
      wait_idle();
      chk("t1_sent", 32'(sent_cnt - base_sent), 32'd4);
      chk("t1_underrun", 32'(underrun_cnt - base_ur), 32'd0);

      // two back-to-back 3-byte packets -> two bursts with a STOP gap
      base_sent = sent_cnt; base_rise = rise_cnt;
      push_seq(8'h11, 3, 1'b1);
      push_seq(8'h21, 3, 1'b1);
      wait_idle();
      chk("t2_sent", 32'(sent_cnt - base_sent), 32'd6);
      chk("t2_bursts", 32'(rise_cnt - base_rise), 32'd2);

      // 16 bytes without last, upstream stalls -> underrun on 17th DATA cycle
      base_sent = sent_cnt; base_ur = underrun_cnt;
      push_seq(8'h40, 16, 1'b0);
      wait_idle();
      chk("t3_sent", 32'(sent_cnt - base_sent), 32'd17);
      chk("t3_underrun", 32'(underrun_cnt - base_ur), 32'd1);

      // full FIFO streamed while upstream keeps pushing
      base_sent = sent_cnt; base_ur = underrun_cnt;
      push_seq(8'h60, 16, 1'b0);
      @(negedge TxDDRClk);
      chk("t4_ready_full", 32'(PktReady), 32'd0);
      push_seq(8'h70, 8, 1'b1);
      wait_idle();
      chk("t4_sent", 32'(sent_cnt - base_sent), 32'd24);
      chk("t4_underrun", 32'(underrun_cnt - base_ur), 32'd0);

      // reset after 2 of 5 bytes, then a fresh packet
      base_sent = sent_cnt;
      push_seq(8'hB1, 5, 1'b1);
      t = 0;
      while (sent_cnt < base_sent + 2 && t < 1000) begin
         @(posedge TxDDRClk);
         t++;
      end
      chk("t5_reach", 32'(sent_cnt - base_sent), 32'd2);
      #2 TxRst = 1'b1;
      #1;
      chk("t5_rst_hstx", 32'(HSTX_EN), 32'd0);
      chk("t5_rst_txdata", 32'(TxData), 32'd0);
      chk("t5_rst_busy", 32'(BurstActive), 32'd0);
      chk("t5_rst_ready", 32'(PktReady), 32'd1);
      exp_q.delete();
      expect_fall = 1'b0;
      @(posedge TxDDRClk);
      #2 TxRst = 1'b0;
      wait_idle();
      base_sent = sent_cnt;
      push_seq(8'hC1, 3, 1'b1);
      wait_idle();
      chk("t5_sent_after", 32'(sent_cnt - base_sent), 32'd3);

      // single-byte packet
      base_sent = sent_cnt; base_ur = underrun_cnt;
      push_seq(8'h5A, 1, 1'b1);
      wait_idle();
      chk("t6_sent", 32'(sent_cnt - base_sent), 32'd1);
      chk("t6_underrun", 32'(underrun_cnt - base_ur), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
